// File: rtl/axis_ram_pkg.sv
// Shared definitions for the RAM reader/writer DMA pair: burst constants,
// the address FSM state type and a ceiling-log2 helper.
package axis_ram_pkg;

   localparam int         BURST_LEN  = 16;
   localparam logic [3:0] ARLEN      = 4'd15;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [3:0] AXCACHE    = 4'b0110;

   typedef enum logic {
      IDLE,
      REQ
   } state_t;

   function automatic int clogb2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/axis_ram_reader_if.sv
// AXI3 read channels plus the AXI4-Stream output of the RAM reader.
// master = the reader, slave = memory/interconnect and stream sink.
interface axis_ram_reader_if #(
   parameter int AXI_ID_WIDTH     = 6,
   parameter int AXI_ADDR_WIDTH   = 32,
   parameter int AXI_DATA_WIDTH   = 64,
   parameter int AXIS_TDATA_WIDTH = 64
);

   logic [AXI_ID_WIDTH-1:0]     m_axi_arid;
   logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr;
   logic [3:0]                  m_axi_arlen;
   logic [2:0]                  m_axi_arsize;
   logic [1:0]                  m_axi_arburst;
   logic [3:0]                  m_axi_arcache;
   logic                        m_axi_arvalid;
   logic                        m_axi_arready;
   logic [AXI_ID_WIDTH-1:0]     m_axi_rid;
   logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata;
   logic [1:0]                  m_axi_rresp;
   logic                        m_axi_rlast;
   logic                        m_axi_rvalid;
   logic                        m_axi_rready;
   logic                        m_axis_tready;
   logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata;
   logic                        m_axis_tvalid;

   modport master (
      output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
             m_axi_arburst, m_axi_arcache, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      output m_axi_rready,
      input  m_axis_tready,
      output m_axis_tdata, m_axis_tvalid
   );

   modport slave (
      input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
             m_axi_arburst, m_axi_arcache, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      input  m_axi_rready,
      output m_axis_tready,
      input  m_axis_tdata, m_axis_tvalid
   );

endinterface

// File: rtl/axis_ram_reader_fifo.sv
// Width-converting first-word-fall-through sync FIFO with xpm_fifo_sync ordering
// (first written word's low bits leave first). Occupancy is reported in write words.
module axis_ram_reader_fifo
   import axis_ram_pkg::*;
#(
   parameter int  WR_WIDTH = 64,
   parameter int  RD_WIDTH = 64,
   parameter int  DEPTH    = 512,
   localparam int CNT_W    = clogb2(DEPTH) + 1
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                wrEn_i,
   input  logic [WR_WIDTH-1:0] din_i,
   input  logic                rdEn_i,
   output logic [RD_WIDTH-1:0] dout_o,
   output logic                empty_o,
   output logic [CNT_W-1:0]    wrDataCount_o
);

   localparam int PW = clogb2(DEPTH);

   logic [WR_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]       wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]    count_q, count_d, popCnt;
   logic                wrAccept;

   assign wrAccept      = wrEn_i && (count_q != CNT_W'(DEPTH));
   assign wrDataCount_o = count_q;

   generate
      if (RD_WIDTH <= WR_WIDTH) begin : g_narrow
         // One stored word is handed out as RATIO consecutive slices, lowest first.
         localparam int RATIO = WR_WIDTH / RD_WIDTH;
         localparam int SW    = (RATIO > 1) ? clogb2(RATIO) : 1;

         logic [SW-1:0] sub_q, sub_d;
         logic          lastSub;

         assign lastSub = (sub_q == SW'(RATIO - 1));
         assign empty_o = (count_q == '0);
         assign dout_o  = mem[rdPtr_q][sub_q*RD_WIDTH +: RD_WIDTH];

         always_comb begin
            sub_d  = sub_q;
            popCnt = '0;
            if (rdEn_i && !empty_o) begin
               sub_d = lastSub ? '0 : sub_q + SW'(1);
               if (lastSub) begin
                  popCnt = CNT_W'(1);
               end
            end
         end

         always_ff @(posedge aclk) begin
            if (!aresetn) begin
               sub_q <= '0;
            end else begin
               sub_q <= sub_d;
            end
         end
      end else begin : g_wide
         // RATIO stored words are glued together, oldest in the low bits.
         localparam int RATIO = RD_WIDTH / WR_WIDTH;

         assign empty_o = (count_q < CNT_W'(RATIO));
         assign popCnt  = (rdEn_i && !empty_o) ? CNT_W'(RATIO) : '0;

         always_comb begin
            dout_o = '0;
            for (int k = 0; k < RATIO; k++) begin
               dout_o[k*WR_WIDTH +: WR_WIDTH] = mem[rdPtr_q + PW'(k)];
            end
         end
      end
   endgenerate

   always_comb begin
      wrPtr_d = wrPtr_q + PW'(wrAccept);
      rdPtr_d = rdPtr_q + PW'(popCnt);
      count_d = count_q + CNT_W'(wrAccept) - popCnt;
   end

   always_ff @(posedge aclk) begin
      if (wrAccept) begin
         mem[wrPtr_q] <= din_i;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/axis_ram_reader.sv
// Streams a circular RAM buffer out over AXI4-Stream using 16-beat AXI3 INCR reads.
// Define AXIS_RAM_READER_RRESP_EN to add the sticky err_flag output (rresp/rlast checks).
module axis_ram_reader
   import axis_ram_pkg::*;
#(
   parameter int ADDR_WIDTH       = 20,
   parameter int AXI_ID_WIDTH     = 6,
   parameter int AXI_ADDR_WIDTH   = 32,
   parameter int AXI_DATA_WIDTH   = 64,
   parameter int AXIS_TDATA_WIDTH = 64,
   parameter int FIFO_WRITE_DEPTH = 512
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0] cfg_data,
   output logic [ADDR_WIDTH-1:0]     sts_data,
`ifdef AXIS_RAM_READER_RRESP_EN
   output logic                      err_flag,
`endif
   axis_ram_reader_if.master         bus
);

   localparam int SIZE = clogb2(AXI_DATA_WIDTH / 8);
   localparam int CW   = clogb2(FIFO_WRITE_DEPTH) + 1;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [AXI_ID_WIDTH-1:0] arId_q, arId_d;
   logic [CW-1:0]           reserved_q, reserved_d;
   logic [CW-1:0]           wrCount, avail;
   logic                    arHs, rBeat, fifoEmpty;

   // Credits: FIFO space not yet spoken for by an outstanding burst.
   assign avail = CW'(FIFO_WRITE_DEPTH) - wrCount - reserved_q;
   assign arHs  = (state_q == REQ) && bus.m_axi_arready;
   // Beats with nothing outstanding are strays from before a reset and are dropped.
   assign rBeat = bus.m_axi_rvalid && (reserved_q != '0);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      arId_d     = arId_q;
      reserved_d = reserved_q;
      case (state_q)
         IDLE: begin
            if (avail >= CW'(BURST_LEN)) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.m_axi_arready && (avail < CW'(2 * BURST_LEN))) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (arHs) begin
         addr_d     = addr_q + ADDR_WIDTH'(BURST_LEN);
         arId_d     = arId_q + AXI_ID_WIDTH'(1);
         reserved_d = reserved_d + CW'(BURST_LEN);
      end
      if (rBeat) begin
         reserved_d = reserved_d - CW'(1);
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         arId_q     <= '0;
         reserved_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         arId_q     <= arId_d;
         reserved_q <= reserved_d;
      end
   end

   assign sts_data          = addr_q;
   assign bus.m_axi_arid    = arId_q;
   assign bus.m_axi_araddr  = cfg_data + (AXI_ADDR_WIDTH'(addr_q) << SIZE);
   assign bus.m_axi_arlen   = ARLEN;
   assign bus.m_axi_arsize  = 3'(SIZE);
   assign bus.m_axi_arburst = BURST_INCR;
   assign bus.m_axi_arcache = AXCACHE;
   assign bus.m_axi_arvalid = (state_q == REQ);
   assign bus.m_axi_rready  = 1'b1;
   assign bus.m_axis_tvalid = !fifoEmpty;

   axis_ram_reader_fifo #(
      .WR_WIDTH (AXI_DATA_WIDTH),
      .RD_WIDTH (AXIS_TDATA_WIDTH),
      .DEPTH    (FIFO_WRITE_DEPTH)
   ) u_fifo (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .wrEn_i        (rBeat),
      .din_i         (bus.m_axi_rdata),
      .rdEn_i        (bus.m_axis_tvalid && bus.m_axis_tready),
      .dout_o        (bus.m_axis_tdata),
      .empty_o       (fifoEmpty),
      .wrDataCount_o (wrCount)
   );

`ifdef AXIS_RAM_READER_RRESP_EN
   logic [3:0] beat_q;
   logic       errFlag_q;
   logic       unusedBits;

   // The 16th beat of every burst must carry rlast, no other beat may.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         beat_q    <= '0;
         errFlag_q <= 1'b0;
      end else if (rBeat) begin
         beat_q <= beat_q + 4'd1;
         if (bus.m_axi_rresp[1] || (bus.m_axi_rlast != (beat_q == 4'd15))) begin
            errFlag_q <= 1'b1;
         end
      end
   end

   assign err_flag   = errFlag_q;
   assign unusedBits = ^{bus.m_axi_rid, bus.m_axi_rresp[0]};
`else
   logic unusedBits;
   assign unusedBits = ^{bus.m_axi_rid, bus.m_axi_rresp, bus.m_axi_rlast};
`endif

endmodule

// File: tb/tb_axis_ram_reader.sv
// Directed bench for axis_ram_reader: small buffer (256 beats) and 64-beat FIFO so
// wrap-around, credit exhaustion, ID wrap and mid-run reset are reached quickly.
module tb_axis_ram_reader;

   localparam int          ADDR_WIDTH = 8;
   localparam int          ID_W       = 6;
   localparam int          AW         = 32;
   localparam int          DW         = 64;
   localparam int          TW         = 64;
   localparam int          DEPTH      = 64;
   localparam logic [31:0] BASE       = 32'h1000_0000;

   logic                  aclk = 1'b0;
   logic                  aresetn;
   logic [AW-1:0]         cfgData;
   logic [ADDR_WIDTH-1:0] stsData;
`ifdef AXIS_RAM_READER_RRESP_EN
   logic                  errFlag;
`endif

   int checks   = 0;
   int errors   = 0;
   int consumed = 0;
   int arBase   = 0;
   bit rEnable  = 1'b1;

   int          arCount  = 0;
   int          beatIdx  = 0;
   int          burstNum = 0;
   logic [31:0] pending [$];
   logic [31:0] arAddrLog [$];
   logic [5:0]  arIdLog [$];

   axis_ram_reader_if #(
      .AXI_ID_WIDTH(ID_W), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXIS_TDATA_WIDTH(TW)
   ) bus ();

   axis_ram_reader #(
      .ADDR_WIDTH(ADDR_WIDTH), .AXI_ID_WIDTH(ID_W), .AXI_ADDR_WIDTH(AW),
      .AXI_DATA_WIDTH(DW), .AXIS_TDATA_WIDTH(TW), .FIFO_WRITE_DEPTH(DEPTH)
   ) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .cfg_data (cfgData),
      .sts_data (stsData),
`ifdef AXIS_RAM_READER_RRESP_EN
      .err_flag (errFlag),
`endif
      .bus      (bus)
   );

   always #5 aclk = ~aclk;

   // RAM model: logs each AR at the negedge before its handshake edge, then returns
   // one beat per enabled cycle whose data is the buffer beat index.
   always begin
      @(negedge aclk);
      if (aresetn && bus.m_axi_arvalid && bus.m_axi_arready) begin
         arAddrLog.push_back(bus.m_axi_araddr);
         arIdLog.push_back(bus.m_axi_arid);
         pending.push_back(bus.m_axi_araddr);
         arCount++;
      end
      @(posedge aclk);
      #1;
      if (!aresetn) begin
         pending.delete();
         beatIdx = 0;
         bus.m_axi_rvalid = 1'b0;
      end else begin
         if (bus.m_axi_rvalid) begin
            if (beatIdx == 15) begin
               beatIdx = 0;
               burstNum++;
               void'(pending.pop_front());
            end else begin
               beatIdx++;
            end
         end
         if (pending.size() != 0 && rEnable) begin
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = 64'(((pending[0] - BASE) >> 3) + 32'(beatIdx));
            bus.m_axi_rlast  = (beatIdx == 15);
            bus.m_axi_rresp  = (burstNum == 3 && beatIdx == 5) ? 2'b10 : 2'b00;
         end else begin
            bus.m_axi_rvalid = 1'b0;
            bus.m_axi_rlast  = 1'b0;
            bus.m_axi_rresp  = 2'b00;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drains the stream until 'target' beats have been taken since the last reset,
   // checking each beat against the running index; tready drops right after.
   task automatic applyStimulus(input int target, input bit gaps, input int maxCycles);
      int cyc;
      cyc = 0;
      while (consumed < target && cyc < maxCycles) begin
         @(posedge aclk);
         #1;
         bus.m_axis_tready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         rEnable           = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         @(negedge aclk);
         cyc++;
         if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            checkOutput("tdata", bus.m_axis_tdata, 64'(consumed % 256));
            consumed++;
         end
         checkOutput("credit", 64'((arCount - arBase) * 16 - consumed <= DEPTH), 64'(1));
      end
      checkOutput("stream_done", 64'(consumed), 64'(target));
      @(posedge aclk);
      #1;
      bus.m_axis_tready = 1'b0;
      rEnable           = 1'b1;
   endtask

   initial begin
      aresetn           = 1'b0;
      cfgData           = BASE;
      bus.m_axi_arready = 1'b0;
      bus.m_axis_tready = 1'b0;
      bus.m_axi_rvalid  = 1'b0;
      bus.m_axi_rdata   = '0;
      bus.m_axi_rresp   = 2'b00;
      bus.m_axi_rlast   = 1'b0;
      bus.m_axi_rid     = '0;

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      checkOutput("rst_arvalid", 64'(bus.m_axi_arvalid), 64'(0));
      checkOutput("rst_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
      checkOutput("rst_sts", 64'(stsData), 64'(0));
      checkOutput("arlen", 64'(bus.m_axi_arlen), 64'(15));
      checkOutput("arsize", 64'(bus.m_axi_arsize), 64'(3));
      checkOutput("arburst", 64'(bus.m_axi_arburst), 64'(1));
      checkOutput("arcache", 64'(bus.m_axi_arcache), 64'(6));
      checkOutput("rready", 64'(bus.m_axi_rready), 64'(1));
`ifdef AXIS_RAM_READER_RRESP_EN
      checkOutput("rst_err", 64'(errFlag), 64'(0));
`endif

      // arready held low: first request must sit perfectly still.
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(posedge aclk);
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         checkOutput("hold_arvalid", 64'(bus.m_axi_arvalid), 64'(1));
         checkOutput("hold_araddr", 64'(bus.m_axi_araddr), 64'(BASE));
         checkOutput("hold_arid", 64'(bus.m_axi_arid), 64'(0));
      end
      checkOutput("hold_count", 64'(arCount), 64'(0));

      // With no sink the 64-beat FIFO allows exactly four bursts.
      @(posedge aclk);
      #1;
      bus.m_axi_arready = 1'b1;
      repeat (120) @(posedge aclk);
      @(negedge aclk);
      checkOutput("fill_arcount", 64'(arCount), 64'(4));
      checkOutput("fill_arvalid", 64'(bus.m_axi_arvalid), 64'(0));
      checkOutput("fill_sts", 64'(stsData), 64'(8'h40));
      checkOutput("fill_tvalid", 64'(bus.m_axis_tvalid), 64'(1));
      checkOutput("fill_tdata", bus.m_axis_tdata, 64'(0));

      applyStimulus(1200, 1'b0, 4000);
      applyStimulus(1808, 1'b1, 6000);

      repeat (150) @(posedge aclk);
      @(negedge aclk);
      checkOutput("q_arvalid", 64'(bus.m_axi_arvalid), 64'(0));
      checkOutput("q_full", 64'(arCount * 16), 64'(consumed + DEPTH));
      checkOutput("q_sts", 64'(stsData), 64'((arCount * 16) % 256));
      checkOutput("q_tvalid", 64'(bus.m_axis_tvalid), 64'(1));
      checkOutput("q_tdata", bus.m_axis_tdata, 64'(consumed % 256));
`ifdef AXIS_RAM_READER_RRESP_EN
      checkOutput("err_set", 64'(errFlag), 64'(1));
`endif
      for (int i = 0; i < arCount; i++) begin
         checkOutput("log_araddr", 64'(arAddrLog[i]), 64'(BASE + 32'(128 * (i % 16))));
         checkOutput("log_arid", 64'(arIdLog[i]), 64'(i % 64));
      end

      // Reset while bursts are in flight: everything restarts from index 0.
      applyStimulus(consumed + 40, 1'b0, 500);
      #1;
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      checkOutput("mid_arvalid", 64'(bus.m_axi_arvalid), 64'(0));
      checkOutput("mid_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
      checkOutput("mid_sts", 64'(stsData), 64'(0));
`ifdef AXIS_RAM_READER_RRESP_EN
      checkOutput("mid_err", 64'(errFlag), 64'(0));
`endif
      consumed = 0;
      arBase   = arCount;
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      applyStimulus(160, 1'b1, 2000);

      repeat (150) @(posedge aclk);
      @(negedge aclk);
      checkOutput("end_arcount", 64'(arCount - arBase), 64'(14));
      checkOutput("end_sts", 64'(stsData), 64'(8'hE0));
      checkOutput("end_arvalid", 64'(bus.m_axi_arvalid), 64'(0));
      checkOutput("end_tdata", bus.m_axis_tdata, 64'(160));
      for (int i = arBase; i < arCount; i++) begin
         checkOutput("end_araddr", 64'(arAddrLog[i]), 64'(BASE + 32'(128 * (i - arBase))));
         checkOutput("end_arid", 64'(arIdLog[i]), 64'(i - arBase));
      end
`ifdef AXIS_RAM_READER_RRESP_EN
      checkOutput("end_err", 64'(errFlag), 64'(0));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
